// File: rtl/mac_neuron_scheduler.sv
// Sequences one shared MAC datapath through every output-neuron sum of a frame.
// Define MAC_NEURON_SCHEDULER_ARGMAX_EN to add the class_idx/class_valid argmax outputs.
module mac_neuron_scheduler #(
    parameter int N_NEURONS = 10,
    parameter int N_INPUTS  = 785,
    parameter int PIPE_LAT  = 3,
    parameter int ACC_W     = 26,
    parameter int PIX_W     = 10,
    parameter int WADDR_W   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic [PIX_W-1:0]   pix_idx,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               mac_clr,
    output logic               mac_en,
    input  logic [ACC_W-1:0]   acc_in,
    output logic               res_valid,
    output logic [3:0]         res_idx,
    output logic [ACC_W-1:0]   res_data,
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
    output logic [3:0]         class_idx,
    output logic               class_valid,
`endif
    output logic               done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_CLEAR | clear MAC accumulator for the current neuron
    // S_FEED  | stream N_INPUTS operand pairs into the MAC
    // S_DRAIN | wait PIPE_LAT cycles for the MAC pipeline to settle
    // S_STORE | present acc_in as the neuron result
    // S_DONE  | frame-complete strobe

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [3:0]       LAST_NEURON = 4'(N_NEURONS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX    = PIX_W'(N_INPUTS - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD    = DRN_W'(PIPE_LAT - 1);

    state_t             state, state_nxt;
    logic [3:0]         neuron;
    logic [DRN_W-1:0]   drn_cnt;
    logic [3:0]         res_idx_q;
    logic [ACC_W-1:0]   res_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Results are shown combinationally during STORE and held from the captured copy afterwards.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        res_valid = 1'b0;
        res_idx   = res_idx_q;
        res_data  = res_data_q;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                mac_en = 1'b1;
                if (pix_idx == LAST_PIX) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (drn_cnt == '0) state_nxt = S_STORE;
            S_STORE: begin
                res_valid = 1'b1;
                res_idx   = neuron;
                res_data  = acc_in;
                state_nxt = (neuron == LAST_NEURON) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // wgt_addr runs continuously across neurons, so it lands on the next base when FEED ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neuron     <= '0;
            pix_idx    <= '0;
            wgt_addr   <= '0;
            drn_cnt    <= '0;
            res_idx_q  <= '0;
            res_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neuron   <= '0;
                        pix_idx  <= '0;
                        wgt_addr <= '0;
                    end
                end
                S_FEED: begin
                    wgt_addr <= wgt_addr + WADDR_W'(1);
                    if (pix_idx == LAST_PIX) begin
                        pix_idx <= '0;
                        drn_cnt <= DRN_LOAD;
                    end else begin
                        pix_idx <= pix_idx + PIX_W'(1);
                    end
                end
                S_DRAIN: if (drn_cnt != '0) drn_cnt <= drn_cnt - DRN_W'(1);
                S_STORE: begin
                    res_idx_q  <= neuron;
                    res_data_q <= acc_in;
                    if (neuron != LAST_NEURON) neuron <= neuron + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
    logic signed [ACC_W-1:0] max_q;
    logic [3:0]              max_idx_q;
    logic [3:0]              class_idx_q;

    // Neuron 0 seeds the maximum; strict compare keeps the lower index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q       <= '0;
            max_idx_q   <= '0;
            class_idx_q <= '0;
        end else begin
            if (state == S_STORE && (neuron == 4'd0 || $signed(acc_in) > max_q)) begin
                max_q     <= acc_in;
                max_idx_q <= neuron;
            end
            if (state == S_DONE) class_idx_q <= max_idx_q;
        end
    end

    assign class_valid = (state == S_DONE);
    assign class_idx   = (state == S_DONE) ? max_idx_q : class_idx_q;
`endif

endmodule

// File: tb/tb_mac_neuron_scheduler.sv
// Scoreboard bench for mac_neuron_scheduler: expected results queued at start, popped by a monitor.
module tb_mac_neuron_scheduler;

    localparam int P     = 790;
    localparam int T_DONE = 7901;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [25:0] acc_in = '0;
    logic        busy, mac_clr, mac_en, res_valid, done;
    logic [9:0]  pix_idx;
    logic [12:0] wgt_addr;
    logic [3:0]  res_idx;
    logic [25:0] res_data;
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
    logic [3:0]  class_idx;
    logic        class_valid;
`endif

    mac_neuron_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .pix_idx(pix_idx), .wgt_addr(wgt_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .acc_in(acc_in), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
        .class_idx(class_idx), .class_valid(class_valid),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rel;
        logic [3:0]  idx;
        logic [25:0] data;
    } res_t;

    res_t       exp_q[$];
    int         done_q[$];
    logic [3:0] cls_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_cyc = 0;
    bit chk_on = 1'b0;
    int acc_mode = 0;
    int cur_vals[10];
    int t_const[10] = '{5, -3, 100, 100, 7, 0, -1, 2, 3, 4};
    int t_neg[10]   = '{-50, -10, -20, -30, -40, -60, -70, -80, -90, -15};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int term(input int addr, input int pix);
        return ((addr * 7 + pix * 3) % 11) - 5;
    endfunction

    function automatic int sum_for(input int k);
        int s = 0;
        for (int j = 0; j < 785; j++) s += term(k * 785 + j, j);
        return s;
    endfunction

    function automatic logic [63:0] outvec();
        logic [63:0] v;
        v = 64'({busy, pix_idx, wgt_addr, mac_clr, mac_en, res_valid, res_idx, res_data, done});
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
        v = v | (64'({class_idx, class_valid}) << 58);
`endif
        return v;
    endfunction

`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
    function automatic logic [3:0] exp_argmax();
        int best = 0;
        for (int k = 1; k < 10; k++) if (cur_vals[k] > cur_vals[best]) best = k;
        return 4'(best);
    endfunction
`endif

    // MAC datapath model: three delay stages so the final sum appears 3 cycles after the last mac_en.
    int macc = 0, d0 = 0, d1 = 0, d2 = 0;
    always @(negedge clk) begin
        int rel, k;
        rel = cyc - s_cyc;
        if (mac_clr)     macc = 0;
        else if (mac_en) macc = macc + term(int'(wgt_addr), int'(pix_idx));
        if (acc_mode == 1) begin
            k = (rel - 1) / P;
            if (k < 0) k = 0;
            if (k > 9) k = 9;
            acc_in = 26'(cur_vals[k]);
        end else begin
            acc_in = 26'(d2);
        end
        d2 = d1;
        d1 = d0;
        d0 = macc;
    end

    always @(negedge clk) begin
        int rel, k, ph, dq;
        res_t e;
        logic busy_x, clr_x, en_x, rv_x, dn_x;
        logic [9:0]  pix_x;
        logic [12:0] wgt_x;
        rel = cyc - s_cyc;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_res_valid idx=%0d cycle=%0d", res_idx, cyc);
            end else begin
                e = exp_q.pop_front();
                check("res_cycle", 64'(rel), 64'(e.rel));
                check("res_idx", 64'(res_idx), 64'(e.idx));
                check("res_data", 64'(res_data), 64'(e.data));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_done cycle=%0d", cyc);
            end else begin
                dq = done_q.pop_front();
                check("done_cycle", 64'(rel), 64'(dq));
            end
        end
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
        if (class_valid) begin
            if (cls_q.size() == 0) begin
                total++; bad++;
                $display("FAIL stray_class_valid cycle=%0d", cyc);
            end else begin
                check("class_idx", 64'(class_idx), 64'(cls_q.pop_front()));
            end
        end
`endif
        if (chk_on && rel >= 1) begin
            busy_x = 0; clr_x = 0; en_x = 0; rv_x = 0; dn_x = 0; pix_x = '0; wgt_x = '0;
            if (rel <= T_DONE) begin
                busy_x = 1;
                if (rel == T_DONE) begin
                    dn_x = 1;
                end else begin
                    k  = (rel - 1) / P;
                    ph = (rel - 1) % P;
                    if (ph == 0) clr_x = 1;
                    else if (ph <= 785) begin
                        en_x  = 1;
                        pix_x = 10'(ph - 1);
                        wgt_x = 13'(k * 785 + ph - 1);
                    end else if (ph == 789) rv_x = 1;
                end
            end
            check("ctrl", 64'({busy, mac_clr, mac_en, res_valid, done,
                               en_x ? pix_idx : 10'd0, en_x ? wgt_addr : 13'd0}),
                          64'({busy_x, clr_x, en_x, rv_x, dn_x, pix_x, wgt_x}));
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
            check("class_valid", 64'(class_valid), 64'(dn_x));
`endif
        end
    end

    // Queues expectations, then presents start for one cycle or holds it (re-pulsed in the DONE cycle).
    task automatic start_frame(input int mode, input bit hold);
        res_t e;
        @(negedge clk);
        acc_mode = mode;
        s_cyc    = cyc;
        chk_on   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e.rel  = P * (k + 1);
            e.idx  = 4'(k);
            e.data = 26'(cur_vals[k]);
            exp_q.push_back(e);
        end
        done_q.push_back(T_DONE);
`ifdef MAC_NEURON_SCHEDULER_ARGMAX_EN
        cls_q.push_back(exp_argmax());
`endif
        start = 1'b1;
        if (hold) begin
            repeat (7900) @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic run_frame(input int mode, input bit hold);
        start_frame(mode, hold);
        while (cyc - s_cyc < 7920) @(negedge clk);
        check("frame_drained", 64'(exp_q.size() + done_q.size() + cls_q.size()), 64'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outvec(), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++) cur_vals[k] = sum_for(k);
        run_frame(0, 1'b0);

        cur_vals = t_const;
        run_frame(1, 1'b0);
        check("res_hold", 64'({res_idx, res_data}), 64'({4'd9, 26'd4}));

        cur_vals = t_neg;
        run_frame(1, 1'b1);

        cur_vals = t_const;
        start_frame(1, 1'b0);
        while (cyc - s_cyc < 3500) @(negedge clk);
        #2;
        chk_on = 1'b0;
        exp_q.delete();
        done_q.delete();
        cls_q.delete();
        rst = 1'b0;
        #1;
        check("async_reset_outputs", outvec(), 64'd0);
        repeat (5) @(negedge clk);
        check("held_reset_outputs", outvec(), 64'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", 64'({busy, mac_en, mac_clr}), 64'd0);

        run_frame(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
